// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//
// Shared types and constants for the bounded up/down counter family.
//
// Contents:
//   cnt_mode_e    : behaviour when the count reaches a boundary
//                   CNT_WRAP -> roll over to the opposite end of 0..lim
//                   CNT_SAT  -> stay pinned at the boundary
//   CNT_MAX_WIDTH : widest counter any member of the family may be built with
//   CNT_MIN_WIDTH : narrowest counter that is still meaningful
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    localparam int CNT_MAX_WIDTH = 32;
    localparam int CNT_MIN_WIDTH = 2;

    // Clamp a requested value into the inclusive range 0..lim. The counter
    // uses this on load so that a programmed value can never place the count
    // outside its legal window.
    function automatic logic [CNT_MAX_WIDTH-1:0] clamp_to_lim(
        input logic [CNT_MAX_WIDTH-1:0] val,
        input logic [CNT_MAX_WIDTH-1:0] lim
    );
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// -----------------------------------------------------------------------------
// mod_counter_next
//
// Purely combinational next-state function for one bounded up/down counter
// channel. Holds no state, so several channels can share this logic by
// instantiating it once per channel around their own registers.
//
// Parameters:
//   WIDTH    : count width in bits
//
// Ports:
//   q        in  WIDTH  current registered count
//   lim      in  WIDTH  inclusive upper bound of the count range
//   up       in  1      direction, 1 = up, 0 = down
//   mode     in  enum   CNT_WRAP or CNT_SAT boundary behaviour
//   load     in  1      load strobe, outranks en
//   load_val in  WIDTH  value to load (clamped to lim)
//   en       in  1      count enable
//   q_next   out WIDTH  count to register on the next edge
//   bnd_evt  out 1      an enabled count step happened at a boundary
// -----------------------------------------------------------------------------
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] lim,
    input  logic             up,
    input  cnt_mode_e        mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] q_next,
    output logic             bnd_evt
);

    logic             at_up_bnd;
    logic             at_dn_bnd;
    logic             at_bnd;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;

    // Boundary detection. The up boundary uses >= so that lowering lim below
    // the current count is treated as already being at the top, which keeps
    // an up count from running on past the new bound.
    assign at_up_bnd = (q >= lim);
    assign at_dn_bnd = (q == '0);
    assign at_bnd    = up ? at_up_bnd : at_dn_bnd;

    // Increment and decrement are only selected away from their boundary, so
    // neither can overflow WIDTH bits nor step outside 0..lim.
    assign q_inc = q + WIDTH'(1);
    assign q_dec = q - WIDTH'(1);

    // A load can never place the count above lim.
    assign load_clamped = (load_val > lim) ? lim : load_val;

    // Next-count selection with load > enable > hold priority. At a boundary
    // the wrap mode jumps to the opposite end of the range, while saturate
    // mode stays on the boundary itself (lim going up, 0 going down).
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_clamped;
        end else if (en) begin
            if (up) begin
                if (!at_up_bnd) begin
                    q_next = q_inc;
                end else if (mode == CNT_WRAP) begin
                    q_next = '0;
                end else begin
                    q_next = lim;
                end
            end else begin
                if (!at_dn_bnd) begin
                    q_next = q_dec;
                end else if (mode == CNT_WRAP) begin
                    q_next = lim;
                end else begin
                    q_next = '0;
                end
            end
        end
    end

    // The boundary event is identical in both modes; in saturate mode it
    // therefore fires on every enabled cycle spent pinned at the boundary.
    assign bnd_evt = en & ~load & at_bnd;

endmodule

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//
// Parametrised up/down counter with a runtime-programmable inclusive limit,
// wrap or saturate boundary behaviour, synchronous load and a registered
// one-cycle terminal-count pulse. Used by timers, tick dividers and address
// sequencers that need a bounded count.
//
// Optional feature macro: COUNTER_OVF_STICKY_EN
//   defined   -> adds the sticky overflow flag ovf and its clear ovf_clr
//   undefined -> neither port nor the flag register exists
//
// Parameters:
//   WIDTH    : count width in bits, 2..32
//   RST_VAL  : count value while reset is held, must fit in WIDTH bits
//
// Ports:
//   clk      in  1      clock, rising edge
//   rst      in  1      asynchronous active-high reset
//   en       in  1      count enable
//   up       in  1      direction, 1 = up, 0 = down
//   mode     in  enum   CNT_WRAP or CNT_SAT
//   lim      in  WIDTH  inclusive upper bound, range is 0..lim
//   load     in  1      synchronous load strobe
//   load_val in  WIDTH  value to load (clamped to lim)
//   q        out WIDTH  registered count
//   tc       out 1      registered terminal-count pulse
//   ovf      out 1      sticky overflow flag        (COUNTER_OVF_STICKY_EN)
//   ovf_clr  in  1      synchronous clear for ovf   (COUNTER_OVF_STICKY_EN)
// -----------------------------------------------------------------------------
module mod_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  cnt_mode_e        mode,
    input  logic [WIDTH-1:0] lim,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_OVF_STICKY_EN
    output logic             ovf,
    input  logic             ovf_clr,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    // Reject illegal builds at elaboration rather than producing a counter
    // whose reset value or width silently truncates.
    if ((WIDTH < CNT_MIN_WIDTH) || (WIDTH > CNT_MAX_WIDTH)) begin : g_bad_width
        $error("mod_counter: WIDTH %0d outside %0d..%0d",
               WIDTH, CNT_MIN_WIDTH, CNT_MAX_WIDTH);
    end

    if ((WIDTH < CNT_MAX_WIDTH) &&
        (64'(RST_VAL) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_rst_val
        $error("mod_counter: RST_VAL %0d does not fit in %0d bits",
               RST_VAL, WIDTH);
    end

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] q_next;
    logic             bnd_evt;

    // All decision making lives in the shared next-state function; this level
    // only owns the registers so that no input reaches an output without
    // passing through a flop.
    mod_counter_next #(
        .WIDTH    (WIDTH)
    ) u_next (
        .q        (q),
        .lim      (lim),
        .up       (up),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .q_next   (q_next),
        .bnd_evt  (bnd_evt)
    );

    // Count and terminal-count registers. tc is registered from the boundary
    // event so it lines up with the wrapped or saturated count it describes;
    // it drops on any cycle without a boundary event, including en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q  <= RST_Q;
            tc <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= bnd_evt;
        end
    end

`ifdef COUNTER_OVF_STICKY_EN
    // Sticky overflow flag. A boundary event outranks a clear arriving on the
    // same edge, so software clearing the flag can never lose a fresh event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (bnd_evt) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
//
// Directed test of mod_counter with WIDTH=4, RST_VAL=0. Expected values are
// hand-computed constants. The sticky overflow section is built only when
// COUNTER_OVF_STICKY_EN is defined, matching the design.
// -----------------------------------------------------------------------------
module tb_mod_counter;
    import counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    cnt_mode_e  mode;
    logic [3:0] lim;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc;
`ifdef COUNTER_OVF_STICKY_EN
    logic       ovf;
    logic       ovf_clr;
`endif

    int checks;
    int errors;

    mod_counter #(
        .WIDTH    (4),
        .RST_VAL  (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .lim      (lim),
        .load     (load),
        .load_val (load_val),
`ifdef COUNTER_OVF_STICKY_EN
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
`endif
        .q        (q),
        .tc       (tc)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs and advance one rising edge; returns 1 time
    // unit after the edge so outputs are sampled clear of it.
    task automatic applyStimulus(input logic e, input logic u, input cnt_mode_e m,
                                 input logic [3:0] l, input logic ld,
                                 input logic [3:0] lv);
        en       = e;
        up       = u;
        mode     = m;
        lim      = l;
        load     = ld;
        load_val = lv;
        @(posedge clk);
        #1;
    endtask

    // Compare q and tc against hand-computed values.
    task automatic checkOutput(input string tag, input logic [3:0] exp_q,
                               input logic exp_tc);
        checks++;
        assert (q === exp_q) else begin
            errors++;
            $error("[TB] FAIL %s q observed %0d expected %0d", tag, q, exp_q);
        end
        checks++;
        assert (tc === exp_tc) else begin
            errors++;
            $error("[TB] FAIL %s tc observed %0b expected %0b", tag, tc, exp_tc);
        end
    endtask

`ifdef COUNTER_OVF_STICKY_EN
    task automatic checkOvf(input string tag, input logic exp_ovf);
        checks++;
        assert (ovf === exp_ovf) else begin
            errors++;
            $error("[TB] FAIL %s ovf observed %0b expected %0b", tag, ovf, exp_ovf);
        end
    endtask
`endif

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #20000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        en       = 1'b0;
        up       = 1'b1;
        mode     = CNT_WRAP;
        lim      = 4'd9;
        load     = 1'b0;
        load_val = 4'd0;
`ifdef COUNTER_OVF_STICKY_EN
        ovf_clr  = 1'b0;
`endif
        $display("[TB] start");

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 4'd0, 1'b0);
`ifdef COUNTER_OVF_STICKY_EN
        checkOvf("reset_ovf", 1'b0);
`endif
        rst = 1'b0;

        // Reset then count: up 3, down 2, idle 3.
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("up1", 4'd1, 1'b0);
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("up3", 4'd3, 1'b0);
        applyStimulus(1, 0, CNT_WRAP, 4'd9, 0, 4'd0);
        applyStimulus(1, 0, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("down2", 4'd1, 1'b0);
        applyStimulus(0, 0, CNT_WRAP, 4'd9, 0, 4'd0);
        applyStimulus(0, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        applyStimulus(0, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("hold", 4'd1, 1'b0);

        // Wrap up through lim=9, then wrap down through 0.
        applyStimulus(0, 1, CNT_WRAP, 4'd9, 1, 4'd8);
        checkOutput("load8", 4'd8, 1'b0);
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("wrap_9", 4'd9, 1'b0);
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("wrap_up", 4'd0, 1'b1);
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("wrap_tc_pulse", 4'd1, 1'b0);
        applyStimulus(1, 0, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("down_to0", 4'd0, 1'b0);
        applyStimulus(1, 0, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("wrap_down", 4'd9, 1'b1);
        applyStimulus(1, 0, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("after_wrap_down", 4'd8, 1'b0);

        // Saturate at lim=5 going up, then at 0 going down.
        applyStimulus(1, 1, CNT_SAT, 4'd5, 1, 4'd4);
        checkOutput("sat_load4", 4'd4, 1'b0);
        applyStimulus(1, 1, CNT_SAT, 4'd5, 0, 4'd0);
        checkOutput("sat_up1", 4'd5, 1'b0);
        applyStimulus(1, 1, CNT_SAT, 4'd5, 0, 4'd0);
        checkOutput("sat_up2", 4'd5, 1'b1);
        applyStimulus(1, 1, CNT_SAT, 4'd5, 0, 4'd0);
        checkOutput("sat_up3", 4'd5, 1'b1);
        applyStimulus(1, 1, CNT_SAT, 4'd5, 0, 4'd0);
        checkOutput("sat_up4", 4'd5, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(1, 0, CNT_SAT, 4'd5, 0, 4'd0);
            checkOutput("sat_down", 4'(i), 1'b0);
        end
        applyStimulus(1, 0, CNT_SAT, 4'd5, 0, 4'd0);
        checkOutput("sat_hold0_a", 4'd0, 1'b1);
        applyStimulus(1, 0, CNT_SAT, 4'd5, 0, 4'd0);
        checkOutput("sat_hold0_b", 4'd0, 1'b1);
        applyStimulus(0, 0, CNT_SAT, 4'd5, 0, 4'd0);
        checkOutput("sat_idle", 4'd0, 1'b0);

        // Load priority and clamp, then lim lowered below q.
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 1, 4'd12);
        checkOutput("load_clamp", 4'd9, 1'b0);
        applyStimulus(1, 1, CNT_WRAP, 4'd4, 0, 4'd0);
        checkOutput("lim_low_wrap", 4'd0, 1'b1);
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 1, 4'd12);
        checkOutput("load_clamp2", 4'd9, 1'b0);
        applyStimulus(1, 1, CNT_SAT, 4'd4, 0, 4'd0);
        checkOutput("lim_low_sat", 4'd4, 1'b1);

        // Free-running range with lim=15.
        applyStimulus(0, 1, CNT_WRAP, 4'd15, 1, 4'd15);
        applyStimulus(1, 1, CNT_WRAP, 4'd15, 0, 4'd0);
        checkOutput("free_wrap", 4'd0, 1'b1);

        // Async reset mid-count at q=7, taking effect between edges.
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 1, 4'd7);
        checkOutput("pre_reset", 4'd7, 1'b0);
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_held", 4'd0, 1'b0);
`ifdef COUNTER_OVF_STICKY_EN
        checkOvf("reset_held_ovf", 1'b0);
`endif
        rst = 1'b0;
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOutput("after_reset", 4'd1, 1'b0);

`ifdef COUNTER_OVF_STICKY_EN
        // Sticky overflow: set, hold, set-beats-clear, clear.
        applyStimulus(0, 1, CNT_WRAP, 4'd9, 1, 4'd9);
        checkOvf("ovf_load_no_set", 1'b0);
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOvf("ovf_set", 1'b1);
        repeat (5) applyStimulus(0, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOvf("ovf_hold", 1'b1);
        applyStimulus(0, 1, CNT_WRAP, 4'd9, 1, 4'd9);
        ovf_clr = 1'b1;
        applyStimulus(1, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOvf("ovf_set_wins", 1'b1);
        applyStimulus(0, 1, CNT_WRAP, 4'd9, 0, 4'd0);
        checkOvf("ovf_clr", 1'b0);
        ovf_clr = 1'b0;
`endif

        // lim=0: count pinned at 0, tc on every enabled cycle.
        applyStimulus(0, 1, CNT_WRAP, 4'd0, 1, 4'd3);
        checkOutput("lim0_load", 4'd0, 1'b0);
        applyStimulus(1, 1, CNT_WRAP, 4'd0, 0, 4'd0);
        checkOutput("lim0_up", 4'd0, 1'b1);
        applyStimulus(1, 0, CNT_WRAP, 4'd0, 0, 4'd0);
        checkOutput("lim0_down", 4'd0, 1'b1);
        applyStimulus(1, 1, CNT_SAT, 4'd0, 0, 4'd0);
        checkOutput("lim0_sat", 4'd0, 1'b1);
        applyStimulus(0, 1, CNT_SAT, 4'd0, 0, 4'd0);
        checkOutput("lim0_idle", 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
